// File: rtl/wshb_mire_writer.sv
// Wishbone 16-bit write master that paints a grid test pattern into the frame buffer.
// Classic single-word handshakes in raster order, with cyc released every BURST_LEN words.
module wshb_mire_writer #(
  parameter int          HDISP     = 640,
  parameter int          VDISP     = 480,
  parameter logic [31:0] BASE_ADR  = 32'h0,
  parameter int          BURST_LEN = 64,
  parameter int          GRID      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        wshb_cyc,
  output logic        wshb_stb,
  output logic        wshb_we,
  output logic [31:0] wshb_adr,
  output logic [15:0] wshb_dat_ms,
  output logic [1:0]  wshb_sel,
  output logic [2:0]  wshb_cti,
  output logic [1:0]  wshb_bte,
  input  logic        wshb_ack
);

  localparam int XW  = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int YW  = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int CW  = $clog2(BURST_LEN + 1);
  localparam int GW  = $clog2(GRID);
  // Grid test may use fewer bits than GW when the pitch exceeds the counter range.
  localparam int GXW = (GW < XW) ? GW : XW;
  localparam int GYW = (GW < YW) ? GW : YW;

  localparam logic [XW-1:0] X_LAST   = XW'(HDISP - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(VDISP - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t        state_reg, state_next;
  logic [XW-1:0] x_reg, x_next;
  logic [YW-1:0] y_reg, y_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [31:0]   adr_reg, adr_next;

  logic          on_grid_x;
  logic          on_grid_y;
  logic          pix_white;
  logic          last_pix;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      cnt_reg   <= '0;
      adr_reg   <= BASE_ADR;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      cnt_reg   <= cnt_next;
      adr_reg   <= adr_next;
    end
  end

  assign last_pix = (x_reg == X_LAST) && (y_reg == Y_LAST);

  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    cnt_next   = cnt_reg;
    adr_next   = adr_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_WRITE;
          x_next     = '0;
          y_next     = '0;
          cnt_next   = '0;
          adr_next   = BASE_ADR;
        end
      end
      S_WRITE: begin
        if (wshb_ack) begin
          // Counters freeze on the last pixel so nothing wraps past the frame.
          if (last_pix) begin
            state_next = S_DONE;
          end else begin
            if (x_reg == X_LAST) begin
              x_next = '0;
              y_next = y_reg + 1'b1;
            end else begin
              x_next = x_reg + 1'b1;
            end
            adr_next = adr_reg + 32'd2;
            if (cnt_reg == CNT_LAST) begin
              cnt_next   = '0;
              state_next = S_PAUSE;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
        end
      end
      S_PAUSE: state_next = S_WRITE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign on_grid_x = (x_reg[GXW-1:0] == '0);
  assign on_grid_y = (y_reg[GYW-1:0] == '0);
  assign pix_white = on_grid_x || on_grid_y || (x_reg == X_LAST) || (y_reg == Y_LAST);

  always_comb begin
    wshb_stb    = (state_reg == S_WRITE);
    wshb_cyc    = wshb_stb;
    wshb_we     = wshb_stb;
    wshb_sel    = wshb_stb ? 2'b11 : 2'b00;
    wshb_dat_ms = (wshb_stb && pix_white) ? 16'hFFFF : 16'h0000;
    wshb_adr    = adr_reg;
    wshb_cti    = 3'b000;
    wshb_bte    = 2'b00;
    busy        = (state_reg == S_WRITE) || (state_reg == S_PAUSE);
    done        = (state_reg == S_DONE);
  end

endmodule

// File: tb/tb_wshb_mire_writer.sv
// Bench for wshb_mire_writer: scoreboarded frame fills, ack latency, restart and reset cases.
module tb_wshb_mire_writer;

  localparam int          HD   = 8;
  localparam int          VD   = 4;
  localparam int          GR   = 4;
  localparam int          BL   = 5;
  localparam logic [31:0] BA   = 32'h100;
  localparam int          NPIX = HD * VD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, cyc, stb, we;
  logic [31:0] adr;
  logic [15:0] dat;
  logic [1:0]  sel, bte;
  logic [2:0]  cti;
  logic        ack = 1'b0;

  always #5 clk = ~clk;

  wshb_mire_writer #(
    .HDISP(HD), .VDISP(VD), .BASE_ADR(BA), .BURST_LEN(BL), .GRID(GR)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .wshb_cyc(cyc), .wshb_stb(stb), .wshb_we(we), .wshb_adr(adr),
    .wshb_dat_ms(dat), .wshb_sel(sel), .wshb_cti(cti), .wshb_bte(bte),
    .wshb_ack(ack)
  );

  typedef struct {
    logic [31:0] adr;
    logic [15:0] dat;
  } wr_t;

  typedef struct {
    int          x;
    int          y;
    logic [15:0] exp;
  } pix_vec_t;

  wr_t         exp_q[$];
  pix_vec_t    tbl[10];
  logic [15:0] capt[NPIX];

  int n_cmp = 0;
  int n_bad = 0;

  int ack_delay = 0;
  int frame_base = 0;
  bit mon_en = 1'b0;

  int          wcnt = 0;
  int          nacks = 0;
  int          gaps = 0;
  int          done_cnt = 0;
  bit          prev_wait = 1'b0;
  bit          prev_gap = 1'b0;
  logic [31:0] prev_adr = '0;
  logic [15:0] prev_dat = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
    end
  endtask

  function automatic logic [15:0] model_pix(input int x, input int y);
    if ((x % GR == 0) || (y % GR == 0) || (x == HD - 1) || (y == VD - 1))
      return 16'hFFFF;
    return 16'h0000;
  endfunction

  task automatic push_frame();
    wr_t e;
    for (int y = 0; y < VD; y++) begin
      for (int x = 0; x < HD; x++) begin
        e.adr = BA + 32'(2 * (y * HD + x));
        e.dat = model_pix(x, y);
        exp_q.push_back(e);
      end
    end
  endtask

  // Slave model + monitor: decide ack for the coming edge and log what it accepts.
  always @(negedge clk) begin
    wr_t e;
    int  idx;
    if (!mon_en) begin
      ack       = 1'b0;
      wcnt      = 0;
      prev_wait = 1'b0;
      prev_gap  = 1'b0;
    end else begin
      if (prev_wait) begin
        check("hold_stb", 32'(stb), 32'd1);
        check("hold_adr", adr, prev_adr);
        check("hold_dat", 32'(dat), 32'(prev_dat));
      end
      if (busy && !cyc) begin
        gaps++;
        check("gap_position",
              32'(((nacks - frame_base) % BL == 0) && ((nacks - frame_base) > 0) && !prev_gap),
              32'd1);
        prev_gap = 1'b1;
      end else begin
        prev_gap = 1'b0;
      end
      if (done) begin
        done_cnt++;
        check("done_busy_low", 32'(busy), 32'd0);
      end
      if (stb && wcnt >= ack_delay) begin
        ack       = 1'b1;
        wcnt      = 0;
        prev_wait = 1'b0;
        nacks++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_write: got adr 0x%0h, want no write", adr);
        end else begin
          e = exp_q.pop_front();
          check("wr_adr", adr, e.adr);
          check("wr_dat", 32'(dat), 32'(e.dat));
          check("wr_ctrl", 32'({we, sel, cti, bte}), 32'({1'b1, 2'b11, 3'b000, 2'b00}));
        end
        idx = int'((adr - BA) >> 1);
        if (adr >= BA && idx < NPIX) capt[idx] = dat;
      end else begin
        ack = 1'b0;
        if (stb) begin
          wcnt++;
          prev_wait = 1'b1;
          prev_adr  = adr;
          prev_dat  = dat;
        end else begin
          prev_wait = 1'b0;
        end
      end
    end
  end

  task automatic run_frame(input string tag, input bit extra_start);
    int gb, db, t;
    frame_base = nacks;
    gb = gaps;
    db = done_cnt;
    push_frame();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    t = 0;
    while (!done && t < 2000) begin
      @(negedge clk);
      t++;
      if (extra_start && t == 10) start = 1'b1;
      if (extra_start && t == 11) start = 1'b0;
    end
    if (t >= 2000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no done after %0d cycles, want done", tag, t);
    end
    repeat (4) @(negedge clk);
    check({tag, "_writes"}, 32'(nacks - frame_base), 32'(NPIX));
    check({tag, "_gaps"}, 32'(gaps - gb), 32'(((NPIX + BL - 1) / BL) - 1));
    check({tag, "_dones"}, 32'(done_cnt - db), 32'd1);
    check({tag, "_sb_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_cyc"}, 32'(cyc), 32'd0);
    $display("frame %s: %0d writes, %0d gaps, %0d done pulses", tag,
             nacks - frame_base, gaps - gb, done_cnt - db);
  endtask

  initial begin
    int t;
    tbl[0] = '{1, 1, 16'h0000};
    tbl[1] = '{4, 1, 16'hFFFF};
    tbl[2] = '{7, 2, 16'hFFFF};
    tbl[3] = '{2, 3, 16'hFFFF};
    tbl[4] = '{0, 0, 16'hFFFF};
    tbl[5] = '{2, 2, 16'h0000};
    tbl[6] = '{5, 2, 16'h0000};
    tbl[7] = '{4, 2, 16'hFFFF};
    tbl[8] = '{3, 0, 16'hFFFF};
    tbl[9] = '{6, 1, 16'h0000};
    for (int i = 0; i < NPIX; i++) capt[i] = 16'hDEAD;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_cyc", 32'(cyc), 32'd0);
    check("rst_stb", 32'(stb), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_adr", adr, BA);
    check("rst_dat", 32'(dat), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_cti_bte", 32'({cti, bte}), 32'd0);
    mon_en = 1'b1;

    ack_delay = 0;
    run_frame("ack0", 1'b0);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("pix_x%0d_y%0d", tbl[i].x, tbl[i].y),
            32'(capt[tbl[i].y * HD + tbl[i].x]), 32'(tbl[i].exp));
    end

    ack_delay = 3;
    run_frame("ack3", 1'b0);

    ack_delay = 0;
    run_frame("restart", 1'b1);

    // Abort a frame while a word is on the bus.
    frame_base = nacks;
    push_frame();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    t = 0;
    while ((nacks - frame_base) < 7 && t < 200) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1 mon_en = 1'b0;
    @(negedge clk);
    t = 0;
    while (!stb && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("stb_before_rst", 32'(stb), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_cyc", 32'(cyc), 32'd0);
    check("rst_mid_stb", 32'(stb), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_adr", adr, BA);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("post_rst_cyc", 32'(cyc), 32'd0);
    $display("reset mid-frame: aborted after %0d writes", nacks - frame_base);
    mon_en = 1'b1;
    run_frame("after_rst", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
